// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states,
// the registered request payload and the lane-offset alignment helper.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned OFF_W  = 2;

    localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_W = 2'd2;
    localparam logic [SIZE_W-1:0] SZ_X = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

    typedef struct packed {
        logic              we;
        logic [SIZE_W-1:0] size;
        logic              is_unsigned;
        logic [OFF_W-1:0]  off;
        logic [XLEN-1:0]   wdata;
    } lsu_req_t;

    // Force-align a byte offset to the natural boundary of the access size
    function automatic logic [OFF_W-1:0] align_off(input logic [SIZE_W-1:0] size,
                                                   input logic [OFF_W-1:0]  off);
        logic [OFF_W-1:0] r;
        r = off;
        if (size == SZ_H) r[0] = 1'b0;
        if (size == SZ_W) r    = '0;
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts/extends load data from a memory word
// and merges byte/half store data into a memory word for read-modify-write.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0]   rd_word,
    input  logic [SIZE_W-1:0] size,
    input  logic [OFF_W-1:0]  off,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data_c,
    output logic [XLEN-1:0]   store_word_c
);

    logic [4:0]      sh;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] ins;

    // Shift the selected lane down for loads and up for stores
    always_comb begin
        sh          = {off, 3'b000};
        shifted     = rd_word >> sh;
        load_data_c = rd_word;
        mask        = '1;
        ins         = wdata;
        case (size)
            SZ_B: begin
                load_data_c = is_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                          : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
                mask        = XLEN'(8'hFF) << sh;
                ins         = {{(XLEN-8){1'b0}}, wdata[7:0]} << sh;
            end
            SZ_H: begin
                load_data_c = is_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                          : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                mask        = XLEN'(16'hFFFF) << sh;
                ins         = {{(XLEN-16){1'b0}}, wdata[15:0]} << sh;
            end
            default: begin
                load_data_c = rd_word;
                mask        = '1;
                ins         = wdata;
            end
        endcase
        store_word_c = (rd_word & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with byte/half read-modify-write stores.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault
// instead of being force-aligned.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS_LOG2 = 25
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            resp_valid,
    output logic [31:0]     resp_rdata,
    output logic            resp_err,
    output logic [31:0]     m_addr,
    output logic [31:0]     m_wr_dat,
    output logic            rd_en,
    output logic            wr_en,
    input  logic [31:0]     m_rd_dat
);

    localparam int unsigned WORD_IDX_W = XLEN - 2;

    lsu_state_e      state, state_n;
    lsu_req_t        req_q, req_n;
    logic            req_ready_n, resp_valid_n, resp_err_n, rd_en_n, wr_en_n;
    logic [XLEN-1:0] resp_rdata_n, m_addr_n, m_wr_dat_n;
    logic [XLEN-1:0] load_data_c, store_word_c;
    logic            oob_c, acc_err_c;

    // Word index beyond the memory depth
    generate
        if (MEM_WORDS_LOG2 >= WORD_IDX_W) begin : g_no_oob
            assign oob_c = 1'b0;
        end else begin : g_oob
            assign oob_c = |(req_addr[XLEN-1:2] >> MEM_WORDS_LOG2);
        end
    endgenerate

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_c;
    assign misalign_c = ((req_size == SZ_H) && req_addr[0]) ||
                        ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    assign acc_err_c  = (req_size == SZ_X) || oob_c || misalign_c;
`else
    assign acc_err_c  = (req_size == SZ_X) || oob_c;
`endif

    lsu_lane_align u_align (
        .rd_word      (m_rd_dat),
        .size         (req_q.size),
        .off          (req_q.off),
        .is_unsigned  (req_q.is_unsigned),
        .wdata        (req_q.wdata),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and next-output decode
    always_comb begin
        state_n      = state;
        req_n        = req_q;
        m_addr_n     = m_addr;
        m_wr_dat_n   = m_wr_dat;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
        rd_en_n      = 1'b0;
        wr_en_n      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    req_n.we          = req_we;
                    req_n.size        = req_size;
                    req_n.is_unsigned = req_unsigned;
                    req_n.off         = align_off(req_size, req_addr[1:0]);
                    req_n.wdata       = req_wdata;
                    m_addr_n          = {2'b00, req_addr[XLEN-1:2]};
                    if (acc_err_c) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else if (req_we && (req_size == SZ_W)) begin
                        state_n    = WR;
                        wr_en_n    = 1'b1;
                        m_wr_dat_n = req_wdata;
                    end else begin
                        state_n = RD;
                        rd_en_n = 1'b1;
                    end
                end
            end
            RD:  state_n = CAP;
            CAP: begin
                if (req_q.we) begin
                    state_n    = WR;
                    wr_en_n    = 1'b1;
                    m_wr_dat_n = store_word_c;
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = load_data_c;
                end
            end
            WR: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        req_ready_n = (state_n == IDLE);
    end

    // Registered outputs and captured request
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            m_addr     <= '0;
            m_wr_dat   <= '0;
            rd_en      <= 1'b0;
            wr_en      <= 1'b0;
        end else begin
            req_q      <= req_n;
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
            m_addr     <= m_addr_n;
            m_wr_dat   <= m_wr_dat_n;
            rd_en      <= rd_en_n;
            wr_en      <= wr_en_n;
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MEM_WORDS_LOG2, default 25, log2 of data-memory depth in 32-bit words.
REQ-002 SHALL have ports, one per line as follows:
  clk  input  1  clock, all state on rising edge
  reset  input  1  reset, synchronous, active-high
  req_valid  input  1  core access request
  req_ready  output  1  unit can accept request
  req_we  input  1  1=store, 0=load
  req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
  req_unsigned  input  1  zero-extend load result
  req_addr  input  32  byte address
  req_wdata  input  32  store data, right-justified
  resp_valid  output  1  one-cycle completion pulse
  resp_rdata  output  32  load result
  resp_err  output  1  access faulted, qualified by resp_valid
  m_addr  output  32  memory word index (req_addr>>2)
  m_wr_dat  output  32  memory write word
  rd_en  output  1  memory read strobe
  wr_en  output  1  memory write strobe
  m_rd_dat  input  32  memory read word, valid cycle after rd_en

Function
REQ-003 SHALL implement FSM states IDLE, RD, CAP, WR, RESP; req_ready=1 only in IDLE.
REQ-004 SHALL accept on req_valid&&req_ready, registering all req_* fields and m_addr.
REQ-005 Load: IDLE->RD (rd_en=1)->CAP (sample m_rd_dat)->RESP; resp_valid 3 cycles after accept.
REQ-006 Word store: IDLE->WR (wr_en=1, m_wr_dat=req_wdata)->RESP; resp_valid 2 cycles after accept.
REQ-007 Byte/half store: read-modify-write IDLE->RD->CAP (merge lane into m_rd_dat)->WR->RESP; resp_valid 4 cycles after accept; unselected bytes preserved.
REQ-008 Lane select: byte lane=addr[1:0], half lane=addr[1]; loads sign-extend unless req_unsigned.
REQ-009 resp_valid SHALL be a single-cycle pulse in RESP, no backpressure; RESP->IDLE unconditionally.
REQ-010 rd_en and wr_en SHALL never be asserted together nor outside RD/WR respectively.
REQ-011 req_size=3 or req_addr[31:2] >= 2**MEM_WORDS_LOG2: no memory strobe, IDLE->RESP, resp_err=1, resp_rdata=0.
REQ-012 Store responses SHALL drive resp_rdata=0, resp_err=0.
REQ-013 req_valid while not ready SHALL be ignored, not queued.

Reset
REQ-014 reset SHALL force IDLE; req_ready=1; resp_valid, resp_err, rd_en, wr_en=0; resp_rdata, m_addr, m_wr_dat=0.
REQ-015 reset mid-operation SHALL abort with no response and no further strobe; a pending RMW write SHALL NOT occur.

Configuration
REQ-016 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL take REQ-011 error path.
REQ-017 Macro undefined: misaligned accesses SHALL force-align (half clears addr[0], word clears addr[1:0]) and complete normally with resp_err=0.

Structure
REQ-018 Package lsu_pkg SHALL hold size encodings (SZ_B, SZ_H, SZ_W) and the FSM state enum.
REQ-019 Combinational sub-module lsu_lane_align SHALL perform load extract/extend and store merge.

Verification
REQ-020 mem[5]=0x8899AABB; load byte addr 0x15 signed -> resp_rdata 0xFFFFFFAA at accept+3, rd_en one cycle, m_addr=5.
REQ-021 Same word, load half addr 0x16 unsigned -> 0x00008899.
REQ-022 mem[2]=0x11223344; store byte 0xEE to addr 0x09 -> wr_en once with m_wr_dat 0x1122EE44, resp_valid at accept+4.
REQ-023 Load word addr 0x1002 -> with LSU_MISALIGN_TRAP_EN resp_err=1 at accept+1, no strobes; without it reads mem[0x400], resp_err=0.
REQ-024 Store word addr 0x8000_0000 (MEM_WORDS_LOG2=25) -> resp_err=1, wr_en never asserted.
REQ-025 Half store accepted, reset asserted in CAP -> no wr_en, no resp_valid, req_ready=1 the cycle after reset.
